// File: rtl/part_init_bridge_if.sv
// Purpose: valid/ready transport bundle between part_init_bridge and the
//          transport adapter.
// Signals: tx_valid/tx_ready/tx_ch/tx_data - outbound snapshot vector
//          rx_valid/rx_ch/rx_data          - inbound target response (no ready)
// Modports: master = bridge side, slave = transport adapter side.
interface part_init_bridge_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 9
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              tx_valid;
  logic              tx_ready;
  logic [CH_W-1:0]   tx_ch;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic [CH_W-1:0]   rx_ch;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output tx_valid, tx_ch, tx_data,
    input  tx_ready, rx_valid, rx_ch, rx_data
  );

  modport slave (
    input  tx_valid, tx_ch, tx_data,
    output tx_ready, rx_valid, rx_ch, rx_data
  );
endinterface

// File: rtl/part_init_bridge.sv
// Purpose: multi-channel initiator-side partition bridge. Snapshots SUT data
//          on each rising mission-clock level, serves pending channels
//          round-robin through one send/receive engine and freezes each
//          mission clock until that channel's response arrives.
// Ports:   clk_i, rst_ni (sync, active-low)
//          bus          - part_init_bridge_if.master (tx_* out, rx_* in)
//          mclk_i       - mission clock levels, one per channel
//          put_en_i     - send the snapshot to the target
//          get_en_i     - wait for the target response
//          sut_data_i   - per-channel SUT data, channel c at [c*DATA_W +: DATA_W]
//          freeze_clk_o - per-channel mission clock hold
//          rcv_valid_o  - one-cycle pulse per channel on stored response
//          rcv_data_o   - last response per channel
//          rx_drop_o    - pulse when an inbound response is discarded
//          ovf_o        - sticky, mission edge while channel still pending
//          wdog_err_o / wdog_ch_o - sticky watchdog timeout and its channel
// Option:  define PART_INIT_WDOG_EN to enable the WAIT-state watchdog.
module part_init_bridge #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DATA_W   = 9,
  parameter int unsigned WDOG_MAX = 10000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  part_init_bridge_if.master       bus,
  input  logic [NUM_CH-1:0]        mclk_i,
  input  logic                     put_en_i,
  input  logic                     get_en_i,
  input  logic [NUM_CH*DATA_W-1:0] sut_data_i,
  output logic [NUM_CH-1:0]        freeze_clk_o,
  output logic [NUM_CH-1:0]        rcv_valid_o,
  output logic [NUM_CH*DATA_W-1:0] rcv_data_o,
  output logic                     rx_drop_o,
  output logic [NUM_CH-1:0]        ovf_o,
  output logic                     wdog_err_o,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wdog_ch_o
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_e;

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          cur_q, cur_d;
  logic [CH_W-1:0]          last_q, last_d;
  logic [NUM_CH-1:0]        mclk_q;
  logic [NUM_CH-1:0]        pending_q, pending_d;
  logic [NUM_CH-1:0]        freeze_q;
  logic [NUM_CH-1:0]        ovf_q, ovf_d;
  logic [NUM_CH-1:0]        rcv_valid_q;
  logic [NUM_CH*DATA_W-1:0] rcv_data_q;
  logic                     rx_drop_q;
  logic [DATA_W-1:0]        hold_q [NUM_CH];

  logic [NUM_CH-1:0]        edge_c, set_c, clr_c, cur_oh_c;
  logic [CH_W-1:0]          pick_c, idx_c;
  logic                     found_c;
  logic                     rx_hit_c, wdog_hit_c, accept_c;
  logic                     tx_valid_c;
  logic [CH_W-1:0]          tx_ch_c;
  logic [DATA_W-1:0]        tx_data_c;

  assign edge_c   = mclk_i & ~mclk_q;
  assign cur_oh_c = NUM_CH'(1) << cur_q;
  assign rx_hit_c = (state_q == ST_WAIT) && bus.rx_valid && (bus.rx_ch == cur_q);

  // A clear and a new edge in the same cycle: the edge starts a fresh pending.
  assign set_c     = edge_c & (~pending_q | clr_c);
  assign pending_d = (pending_q & ~clr_c) | set_c;
  assign ovf_d     = ovf_q | (edge_c & pending_q & ~clr_c);

  // Round-robin: first pending channel after the last one picked.
  always_comb begin
    pick_c  = last_q;
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx_c = CH_W'((int'(last_q) + i) % NUM_CH);
      if (!found_c && pending_q[idx_c]) begin
        pick_c  = idx_c;
        found_c = 1'b1;
      end
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|pending_q) begin
        if (put_en_i)      state_d = ST_SEND;
        else if (get_en_i) state_d = ST_WAIT;
      end
      ST_SEND: if (bus.tx_ready) state_d = get_en_i ? ST_WAIT : ST_IDLE;
      ST_WAIT: if (rx_hit_c || wdog_hit_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and per-state control
  always_comb begin
    cur_d      = cur_q;
    last_d     = last_q;
    clr_c      = '0;
    accept_c   = 1'b0;
    tx_valid_c = 1'b0;
    tx_ch_c    = '0;
    tx_data_c  = '0;
    case (state_q)
      ST_IDLE: if (|pending_q) begin
        cur_d  = pick_c;
        last_d = pick_c;
        if (!put_en_i && !get_en_i) clr_c = NUM_CH'(1) << pick_c;
      end
      ST_SEND: begin
        tx_valid_c = 1'b1;
        tx_ch_c    = cur_q;
        tx_data_c  = hold_q[cur_q];
        if (bus.tx_ready && !get_en_i) clr_c = cur_oh_c;
      end
      ST_WAIT: begin
        if (rx_hit_c) begin
          accept_c = 1'b1;
          clr_c    = cur_oh_c;
        end else if (wdog_hit_c) begin
          clr_c    = cur_oh_c;
        end
      end
      default: ;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      last_q      <= CH_W'(NUM_CH - 1);
      mclk_q      <= '0;
      pending_q   <= '0;
      freeze_q    <= '0;
      ovf_q       <= '0;
      rcv_valid_q <= '0;
      rcv_data_q  <= '0;
      rx_drop_q   <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) hold_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      mclk_q      <= mclk_i;
      pending_q   <= pending_d;
      freeze_q    <= pending_q;
      ovf_q       <= ovf_d;
      rcv_valid_q <= accept_c ? cur_oh_c : '0;
      rx_drop_q   <= bus.rx_valid && !accept_c;
      if (accept_c) rcv_data_q[int'(cur_q)*DATA_W +: DATA_W] <= bus.rx_data;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (set_c[c]) hold_q[c] <= sut_data_i[c*DATA_W +: DATA_W];
      end
    end
  end

`ifdef PART_INIT_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             wdog_err_q;
  logic [CH_W-1:0]  wdog_ch_q;

  assign wdog_hit_c = (state_q == ST_WAIT) && !rx_hit_c && (cnt_q == CNT_W'(WDOG_MAX));

  // Counter is zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      wdog_err_q <= 1'b0;
      wdog_ch_q  <= '0;
    end else begin
      if (state_q != ST_WAIT)                 cnt_q <= '0;
      else if (cnt_q != CNT_W'(WDOG_MAX))     cnt_q <= cnt_q + CNT_W'(1);
      if (wdog_hit_c) begin
        wdog_err_q <= 1'b1;
        wdog_ch_q  <= cur_q;
      end
    end
  end

  assign wdog_err_o = wdog_err_q;
  assign wdog_ch_o  = wdog_ch_q;
`else
  logic unused_wdog_c;

  assign wdog_hit_c    = 1'b0;
  assign wdog_err_o    = 1'b0;
  assign wdog_ch_o     = '0;
  assign unused_wdog_c = ^32'(WDOG_MAX);
`endif

  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_ch     = tx_ch_c;
  assign bus.tx_data   = tx_data_c;
  assign freeze_clk_o  = freeze_q;
  assign rcv_valid_o   = rcv_valid_q;
  assign rcv_data_o    = rcv_data_q;
  assign rx_drop_o     = rx_drop_q;
  assign ovf_o         = ovf_q;
endmodule
